// File: rtl/fwd_pkg.sv
// Shared types and encodings for the forwarding / hazard unit.
//   FWD_REG_AW, FWD_NUM_SRC : default register-address width and sources/instr
//   SEL_RF/SEL_MEM/SEL_WB   : forward-select encodings (0 = no forward)
//   stage_tag_t             : one in-flight instruction tag in the shadow pipe
package fwd_pkg;
  localparam int FWD_REG_AW  = 5;
  localparam int FWD_NUM_SRC = 2;

  localparam int SEL_RF  = 0;
  localparam int SEL_MEM = 1;
  localparam int SEL_WB  = 2;

  typedef struct packed {
    logic                                   valid;
    logic                                   regwrite;
    logic                                   is_load;
    logic [FWD_REG_AW-1:0]                  rd;
    logic [FWD_NUM_SRC-1:0][FWD_REG_AW-1:0] src;
    logic [FWD_NUM_SRC-1:0]                 src_used;
  } stage_tag_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side instruction info in, forward selects / stall / stall counter out.
//   master : pipeline control (drives id_*, flush; reads results)
//   slave  : fwd_hazard_unit
interface fwd_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int REG_AW  = FWD_REG_AW,
  parameter int NUM_SRC = FWD_NUM_SRC,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_regwrite;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_is_load;
  logic                      id_is_branch;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
  logic [NUM_SRC*SEL_W-1:0]  id_fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_regwrite, id_rd, id_is_load,
           id_is_branch, flush,
    input  ex_fwd_sel, id_fwd_sel, stall, stall_cnt
  );
  modport slave (
    input  id_valid, id_src, id_src_used, id_regwrite, id_rd, id_is_load,
           id_is_branch, flush,
    output ex_fwd_sel, id_fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_match.sv
// Priority matcher: one source register against DEPTH in-flight tags.
//   en_i   : source is actually read (gates sel_o only)
//   src_i  : source register
//   wr_i   : per stage valid && regwrite
//   rd_i   : per stage destination
//   skip_i : stages whose result cannot be forwarded
//   sel_o  : smallest eligible matching stage index, else SEL_RF
//   hit_o  : raw per-stage match (ignores en_i and skip_i)
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic                             en_i,
  input  logic [FWD_REG_AW-1:0]            src_i,
  input  logic [DEPTH-1:0]                 wr_i,
  input  logic [DEPTH-1:0][FWD_REG_AW-1:0] rd_i,
  input  logic [DEPTH-1:0]                 skip_i,
  output logic [SEL_W-1:0]                 sel_o,
  output logic [DEPTH-1:0]                 hit_o
);
  always_comb begin
    hit_o = '0;
    for (int k = 0; k < DEPTH; k++)
      hit_o[k] = wr_i[k] && (rd_i[k] != '0) && (rd_i[k] == src_i);
    // Scan oldest to youngest so the youngest producer is written last.
    sel_o = SEL_W'(SEL_RF);
    if (en_i)
      for (int k = DEPTH-1; k >= 0; k--)
        if (hit_o[k] && !skip_i[k]) sel_o = SEL_W'(k);
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit with a shadow pipeline of in-flight tags
// (s0=EX, s1=MEM, s2=WB, ...).
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : ID instruction info + flush in; EX/ID forward selects,
//                  stall and saturating stall counter out
// Tag layout comes from fwd_pkg; REG_AW/NUM_SRC must equal FWD_REG_AW/FWD_NUM_SRC.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = FWD_REG_AW,
  parameter int NUM_SRC = FWD_NUM_SRC,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16,
  parameter int SEL_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  fwd_hazard_unit_if.slave bus
);
  stage_tag_t [DEPTH-1:0]             s_q, s_d;
  stage_tag_t                         id_tag;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               stall, haz;
  logic [DEPTH-1:0]                   tag_wr, ex_skip, id_skip;
  logic [DEPTH-1:0][FWD_REG_AW-1:0]   tag_rd;
  logic [NUM_SRC-1:0][SEL_W-1:0]      ex_sel, id_sel;
  logic [NUM_SRC-1:0][DEPTH-1:0]      id_hit, ex_hit_unused;
  logic                               tail_unused;

  // The oldest stage only matters for its write-back match.
  assign tail_unused = ^{s_q[DEPTH-1].is_load, s_q[DEPTH-1].src,
                         s_q[DEPTH-1].src_used};

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = bus.id_valid;
    id_tag.regwrite = bus.id_regwrite;
    id_tag.is_load  = bus.id_is_load;
    id_tag.rd       = bus.id_rd;
    for (int j = 0; j < NUM_SRC; j++) begin
      id_tag.src[j]      = bus.id_src[j*REG_AW +: REG_AW];
      id_tag.src_used[j] = bus.id_src_used[j];
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      tag_wr[k] = s_q[k].valid && s_q[k].regwrite;
      tag_rd[k] = s_q[k].rd;
    end
    // EX result is never ready for forwarding; a load in MEM is not ready
    // for an ID-stage branch compare either.
    ex_skip          = '0;
    ex_skip[0]       = 1'b1;
    id_skip          = '0;
    id_skip[0]       = 1'b1;
    id_skip[SEL_MEM] = s_q[SEL_MEM].is_load;
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_ex (
      .en_i   (s_q[0].valid && s_q[0].src_used[j]),
      .src_i  (s_q[0].src[j]),
      .wr_i   (tag_wr),
      .rd_i   (tag_rd),
      .skip_i (ex_skip),
      .sel_o  (ex_sel[j]),
      .hit_o  (ex_hit_unused[j])
    );
    fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_id (
      .en_i   (bus.id_valid && bus.id_is_branch && bus.id_src_used[j]),
      .src_i  (id_tag.src[j]),
      .wr_i   (tag_wr),
      .rd_i   (tag_rd),
      .skip_i (id_skip),
      .sel_o  (id_sel[j]),
      .hit_o  (id_hit[j])
    );
  end

  // Load-use (producer load in EX), branch on EX result, branch on MEM load.
  always_comb begin
    haz = 1'b0;
    for (int j = 0; j < NUM_SRC; j++)
      if (bus.id_src_used[j])
        for (int k = 0; k < DEPTH; k++)
          if (id_hit[j][k]) begin
            if (k == 0 && (s_q[0].is_load || bus.id_is_branch)) haz = 1'b1;
            if (k == 1 && bus.id_is_branch && s_q[1].is_load)   haz = 1'b1;
          end
    stall = bus.id_valid && !bus.flush && haz;
  end

  always_comb begin
    s_d[0] = '0;
    if (bus.id_valid && !stall && !bus.flush) s_d[0] = id_tag;
    for (int k = 1; k < DEPTH; k++) s_d[k] = s_q[k-1];
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    bus.ex_fwd_sel = '0;
    bus.id_fwd_sel = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      bus.ex_fwd_sel[j*SEL_W +: SEL_W] = ex_sel[j];
      bus.id_fwd_sel[j*SEL_W +: SEL_W] = id_sel[j];
    end
  end

  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;
endmodule
